// File: rtl/fpnew_noncomp_wb.sv
// Writeback formatter and 2-entry buffer behind the non-computational FP unit.
// Words are formatted on push; sticky fflags accumulate the status of each popped entry.
module fpnew_noncomp_wb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned XLEN    = 64,
  parameter type         TagType = logic
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] result_i,
  input  logic [4:0]       status_i,
  input  logic             extension_bit_i,
  input  logic [9:0]       class_mask_i,
  input  logic             is_class_i,
  input  TagType           tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [XLEN-1:0]  wb_data_o,
  output logic [4:0]       wb_status_o,
  output TagType           tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             fflags_clr_i,
  output logic [4:0]       fflags_o,
  output logic             busy_o
);

  // Fill first, then overlay the result so XLEN == WIDTH leaves no fill bits.
  function automatic logic [XLEN-1:0] format_word(input logic [WIDTH-1:0] res,
                                                  input logic             ext,
                                                  input logic [9:0]       mask,
                                                  input logic             is_class);
    logic [XLEN-1:0] w;
    if (is_class) begin
      w       = '0;
      w[9:0]  = mask;
    end else begin
      w              = {XLEN{ext}};
      w[WIDTH-1:0]   = res;
    end
    return w;
  endfunction

  logic [XLEN-1:0] data_q   [2];
  logic [XLEN-1:0] data_d   [2];
  logic [4:0]      status_q [2];
  logic [4:0]      status_d [2];
  TagType          tag_q    [2];
  TagType          tag_d    [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [4:0]      fflags_q, fflags_d;
  logic            push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign busy_o      = (cnt_q != 2'd0);
  assign wb_data_o   = data_q[rd_ptr_q];
  assign wb_status_o = status_q[rd_ptr_q];
  assign tag_o       = tag_q[rd_ptr_q];
  assign fflags_o    = fflags_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    data_d   = data_q;
    status_d = status_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q]   = format_word(result_i, extension_bit_i, class_mask_i, is_class_i);
        status_d[wr_ptr_q] = status_i;
        tag_d[wr_ptr_q]    = tag_i;
        wr_ptr_d           = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // A pop in a flush cycle is not a retirement, so its flags are not accumulated.
  always_comb begin
    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
    if (pop && !flush_i) begin
      fflags_d = fflags_d | wb_status_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i]   <= '0;
        status_q[i] <= '0;
        tag_q[i]    <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      fflags_q <= 5'b0;
    end else begin
      data_q   <= data_d;
      status_q <= status_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// Directed bench for fpnew_noncomp_wb: formatting table, backpressure, sticky flags,
// flush and asynchronous reset.
module tb_fpnew_noncomp_wb;

  typedef logic [3:0] tag_t;

  logic        clk;
  logic        rst_ni;
  logic [31:0] result_i;
  logic [4:0]  status_i;
  logic        extension_bit_i;
  logic [9:0]  class_mask_i;
  logic        is_class_i;
  tag_t        tag_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_status_o;
  tag_t        tag_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;
  logic        busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  fpnew_noncomp_wb #(
    .WIDTH  (32),
    .XLEN   (64),
    .TagType(tag_t)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .result_i       (result_i),
    .status_i       (status_i),
    .extension_bit_i(extension_bit_i),
    .class_mask_i   (class_mask_i),
    .is_class_i     (is_class_i),
    .tag_i          (tag_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .flush_i        (flush_i),
    .wb_data_o      (wb_data_o),
    .wb_status_o    (wb_status_o),
    .tag_o          (tag_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .fflags_clr_i   (fflags_clr_i),
    .fflags_o       (fflags_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ext;
    logic        cls;
    logic [9:0]  mask;
    logic [4:0]  st;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic ext, input logic cls,
                       input logic [9:0] mask, input logic [4:0] st, input tag_t tg);
    result_i        = res;
    extension_bit_i = ext;
    is_class_i      = cls;
    class_mask_i    = mask;
    status_i        = st;
    tag_i           = tg;
    in_valid_i      = 1'b1;
  endtask

  initial begin
    logic [4:0] exp_ff;

    vecs[0] = '{32'hBF800000, 1'b1, 1'b0, 10'h000, 5'b00000, 64'hFFFFFFFF_BF800000};
    vecs[1] = '{32'hDEADBEEF, 1'b1, 1'b1, 10'h010, 5'b00001, 64'h00000000_00000010};
    vecs[2] = '{32'h3F800000, 1'b0, 1'b0, 10'h3FF, 5'b00010, 64'h00000000_3F800000};
    vecs[3] = '{32'h7FC00000, 1'b1, 1'b0, 10'h000, 5'b00000, 64'hFFFFFFFF_7FC00000};
    vecs[4] = '{32'hFFFFFFFF, 1'b1, 1'b1, 10'h200, 5'b00100, 64'h00000000_00000200};
    vecs[5] = '{32'h00000000, 1'b0, 1'b1, 10'h001, 5'b00000, 64'h00000000_00000001};
    vecs[6] = '{32'h12345678, 1'b0, 1'b0, 10'h155, 5'b00000, 64'h00000000_12345678};

    rst_ni = 1'b0;
    result_i = '0; status_i = '0; extension_bit_i = 1'b0; class_mask_i = '0;
    is_class_i = 1'b0; tag_i = '0; in_valid_i = 1'b0; flush_i = 1'b0;
    out_ready_i = 1'b0; fflags_clr_i = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_wb_data", wb_data_o, 64'd0);
    chk("rst_wb_status", 64'(wb_status_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_fflags", 64'(fflags_o), 64'd0);
    rst_ni = 1'b1;
    step();

    // Streaming table: one push per cycle, always-ready sink, 1-cycle latency
    out_ready_i = 1'b1;
    exp_ff = 5'b0;
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].res, vecs[i].ext, vecs[i].cls, vecs[i].mask, vecs[i].st, tag_t'(i));
      step();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'd1);
      chk($sformatf("vec%0d_data", i), wb_data_o, vecs[i].exp);
      chk($sformatf("vec%0d_status", i), 64'(wb_status_o), 64'(vecs[i].st));
      chk($sformatf("vec%0d_tag", i), 64'(tag_o), 64'(i));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready_o), 64'd1);
      exp_ff = exp_ff | vecs[i].st;
    end
    in_valid_i = 1'b0;
    step();
    chk("stream_drained", 64'(out_valid_o), 64'd0);
    chk("stream_fflags", 64'(fflags_o), 64'(exp_ff));
    fflags_clr_i = 1'b1;
    step();
    fflags_clr_i = 1'b0;
    chk("fflags_cleared", 64'(fflags_o), 64'd0);

    // Backpressure: A, B fill the buffer, C stalls
    out_ready_i = 1'b0;
    drive(32'hAAAA0001, 1'b0, 1'b0, 10'h0, 5'b0, 4'hA);
    step();
    chk("bp_ready_after_1", 64'(in_ready_o), 64'd1);
    drive(32'hBBBB0002, 1'b0, 1'b0, 10'h0, 5'b0, 4'hB);
    step();
    chk("bp_ready_after_2", 64'(in_ready_o), 64'd0);
    chk("bp_busy", 64'(busy_o), 64'd1);
    drive(32'hCCCC0003, 1'b0, 1'b0, 10'h0, 5'b0, 4'hC);
    step();
    chk("bp_stall_ready", 64'(in_ready_o), 64'd0);
    chk("bp_head_A_stalled", wb_data_o, 64'h00000000_AAAA0001);
    out_ready_i = 1'b1;
    #1;
    chk("bp_no_comb_path", 64'(in_ready_o), 64'd0);
    chk("bp_head_A", wb_data_o, 64'h00000000_AAAA0001);
    chk("bp_tag_A", 64'(tag_o), 64'hA);
    step();
    chk("bp_head_B", wb_data_o, 64'h00000000_BBBB0002);
    chk("bp_tag_B", 64'(tag_o), 64'hB);
    chk("bp_ready_reopen", 64'(in_ready_o), 64'd1);
    step();
    in_valid_i = 1'b0;
    chk("bp_head_C", wb_data_o, 64'h00000000_CCCC0003);
    chk("bp_tag_C", 64'(tag_o), 64'hC);
    chk("bp_valid_C", 64'(out_valid_o), 64'd1);
    step();
    chk("bp_drained", 64'(out_valid_o), 64'd0);

    // Sticky flags: NV pop, then NX pop together with clear
    out_ready_i = 1'b0;
    drive(32'h1, 1'b0, 1'b0, 10'h0, 5'b10000, 4'h1);
    step();
    drive(32'h2, 1'b0, 1'b0, 10'h0, 5'b00001, 4'h2);
    step();
    in_valid_i = 1'b0;
    chk("ff_no_accum_on_push", 64'(fflags_o), 64'd0);
    out_ready_i = 1'b1;
    step();
    chk("ff_after_nv", 64'(fflags_o), 64'h10);
    fflags_clr_i = 1'b1;
    step();
    fflags_clr_i = 1'b0;
    chk("ff_clr_with_pop", 64'(fflags_o), 64'h01);
    chk("ff_drained", 64'(out_valid_o), 64'd0);

    // Flush with two entries held, a pop and a (blocked) push in the same cycle
    out_ready_i = 1'b0;
    drive(32'h3, 1'b0, 1'b0, 10'h0, 5'b11110, 4'h3);
    step();
    drive(32'h4, 1'b0, 1'b0, 10'h0, 5'b11110, 4'h4);
    step();
    chk("fl_full", 64'(in_ready_o), 64'd0);
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    drive(32'h5, 1'b0, 1'b0, 10'h0, 5'b11110, 4'h5);
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("fl_out_valid", 64'(out_valid_o), 64'd0);
    chk("fl_busy", 64'(busy_o), 64'd0);
    chk("fl_in_ready", 64'(in_ready_o), 64'd1);
    chk("fl_fflags", 64'(fflags_o), 64'h01);

    // Flush with one entry held and an accepted push: push is discarded
    drive(32'h6, 1'b0, 1'b0, 10'h0, 5'b00000, 4'h6);
    step();
    flush_i = 1'b1;
    drive(32'h7, 1'b0, 1'b0, 10'h0, 5'b00000, 4'h7);
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("fl1_out_valid", 64'(out_valid_o), 64'd0);
    step();
    chk("fl1_stays_empty", 64'(out_valid_o), 64'd0);

    // Post-flush ordering restarts cleanly
    drive(32'h89ABCDEF, 1'b1, 1'b0, 10'h0, 5'b01000, 4'h9);
    step();
    in_valid_i = 1'b0;
    chk("pf_data", wb_data_o, 64'hFFFFFFFF_89ABCDEF);
    chk("pf_tag", 64'(tag_o), 64'h9);
    step();
    chk("pf_fflags", 64'(fflags_o), 64'h09);

    // Asynchronous reset while one entry is held
    out_ready_i = 1'b0;
    drive(32'hBF800000, 1'b1, 1'b0, 10'h0, 5'b00100, 4'hE);
    step();
    in_valid_i = 1'b0;
    chk("ar_held", 64'(out_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid_o), 64'd0);
    chk("ar_busy", 64'(busy_o), 64'd0);
    chk("ar_wb_data", wb_data_o, 64'd0);
    chk("ar_tag", 64'(tag_o), 64'd0);
    chk("ar_fflags", 64'(fflags_o), 64'd0);
    chk("ar_in_ready", 64'(in_ready_o), 64'd1);
    step();
    rst_ni = 1'b1;
    step();
    chk("ar_after_valid", 64'(out_valid_o), 64'd0);
    chk("ar_after_ready", 64'(in_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
